shift_unit: RTL and testbench

SHIFT_UNIT -- requirements
Module: shift_unit

---
 rtl/shift_unit.sv | 122 ++++++++++++
 tb/tb_shift_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_unit.sv
// shift_unit: multi-cycle shift/rotate engine. An accepted request shifts or
// rotates the operand one bit per clock, then publishes the result with a
// one-cycle finished strobe.
module shift_unit #(
    parameter logic [4:0] OP_SHR  = 5'b11100,
    parameter logic [4:0] OP_SHRA = 5'b11101,
    parameter logic [4:0] OP_SHL  = 5'b11110,
    parameter logic [4:0] OP_ROR  = 5'b11111,
    parameter logic [4:0] OP_ROL  = 5'b11011
) (
    input  logic        Clock,
    input  logic        clear,
    input  logic        start,
    input  logic [4:0]  opSelect,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] result,
    output logic        finished,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [4:0]  op_q, op_d;
    logic [31:0] result_q, result_d;
    logic        finished_q, finished_d;
    logic        busy_q, busy_d;
    logic [31:0] step_val;

    // The upper shift-amount bits are don't-care: counts wrap modulo 32.
    logic        unused_b_hi;
    assign unused_b_hi = ^B[31:5];

    // One-bit step of the latched operation; unknown opcodes leave acc alone.
    always_comb begin
        step_val = acc_q;
        if (op_q == OP_SHR) begin
            step_val = {1'b0, acc_q[31:1]};
        end else if (op_q == OP_SHRA) begin
            step_val = {acc_q[31], acc_q[31:1]};
        end else if (op_q == OP_SHL) begin
            step_val = {acc_q[30:0], 1'b0};
        end else if (op_q == OP_ROR) begin
            step_val = {acc_q[0], acc_q[31:1]};
        end else if (op_q == OP_ROL) begin
            step_val = {acc_q[30:0], acc_q[31]};
        end
    end

    // Next-state and next-output logic for the IDLE/SHIFT/DONE sequencer.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        result_d   = result_q;
        finished_d = 1'b0;
        busy_d     = busy_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = A;
                    cnt_d   = B[4:0];
                    op_d    = opSelect;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q != 5'd0) begin
                    acc_d = step_val;
                    cnt_d = cnt_q - 5'd1;
                end else begin
                    result_d   = acc_q;
                    finished_d = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // All state and registered outputs; clear aborts any operation at once.
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            state_q    <= IDLE;
            acc_q      <= 32'd0;
            cnt_q      <= 5'd0;
            op_q       <= 5'd0;
            result_q   <= 32'd0;
            finished_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            result_q   <= result_d;
            finished_q <= finished_d;
            busy_q     <= busy_d;
        end
    end

    assign result   = result_q;
    assign finished = finished_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_shift_unit.sv
// tb_shift_unit: directed scenario tests for shift_unit.
module tb_shift_unit;

    localparam logic [4:0] SHR  = 5'b11100;
    localparam logic [4:0] SHRA = 5'b11101;
    localparam logic [4:0] SHL  = 5'b11110;
    localparam logic [4:0] ROR  = 5'b11111;
    localparam logic [4:0] ROL  = 5'b11011;

    logic        Clock;
    logic        clear;
    logic        start;
    logic [4:0]  opSelect;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] result;
    logic        finished;
    logic        busy;

    int tests;
    int fails;

    shift_unit dut (
        .Clock    (Clock),
        .clear    (clear),
        .start    (start),
        .opSelect (opSelect),
        .A        (A),
        .B        (B),
        .result   (result),
        .finished (finished),
        .busy     (busy)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Presents a request for exactly one edge (edge 0); returns 1 time unit after it.
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
        A = a;
        B = b;
        opSelect = op;
        start = 1'b1;
        @(posedge Clock); #1;
        start = 1'b0;
    endtask

    // Counts edges until finished (bounded), then steps one more edge back to IDLE.
    task automatic wait_finish(output int edges, output int busy_cycles);
        busy_cycles = busy ? 1 : 0;
        edges = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge Clock); #1;
            if (busy) busy_cycles++;
            if (finished) begin
                edges = k;
                break;
            end
        end
        @(posedge Clock); #1;
        if (busy) busy_cycles++;
    endtask

    task automatic test_reset();
        clear = 1'b0;
        start = 1'b0;
        opSelect = 5'd0;
        A = 32'd0;
        B = 32'd0;
        #2;
        tests++; if (result !== 32'd0) begin fails++; $display("FAIL reset_result: got %h want %h", result, 32'd0); end
        tests++; if (finished !== 1'b0) begin fails++; $display("FAIL reset_finished: got %b want 0", finished); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        @(posedge Clock); #1;
        clear = 1'b1;
        $display("[TB] reset checked");
    endtask

    task automatic test_shra();
        int e, bc;
        launch(32'h80000008, 32'd2, SHRA);
        wait_finish(e, bc);
        tests++; if (e !== 3) begin fails++; $display("FAIL shra_latency: got %0d want 3", e); end
        tests++; if (result !== 32'hE0000002) begin fails++; $display("FAIL shra_result: got %h want E0000002", result); end
        tests++; if (bc !== 4) begin fails++; $display("FAIL shra_busy_cycles: got %0d want 4", bc); end
        tests++; if (busy !== 1'b0 || finished !== 1'b0) begin fails++; $display("FAIL shra_idle_after: busy %b finished %b want 0 0", busy, finished); end
        $display("[TB] shra 80000008 by 2 -> %h after edge %0d", result, e);
    endtask

    task automatic test_shr_shl();
        int e, bc;
        launch(32'h80000008, 32'd2, SHR);
        wait_finish(e, bc);
        tests++; if (result !== 32'h20000002) begin fails++; $display("FAIL shr_result: got %h want 20000002", result); end
        $display("[TB] shr 80000008 by 2 -> %h", result);
        launch(32'h00000001, 32'h00000021, SHL);
        wait_finish(e, bc);
        tests++; if (e !== 2) begin fails++; $display("FAIL shl_wrap_latency: got %0d want 2", e); end
        tests++; if (result !== 32'h00000002) begin fails++; $display("FAIL shl_wrap_result: got %h want 00000002", result); end
        $display("[TB] shl 1 by 0x21 -> %h after edge %0d", result, e);
    endtask

    task automatic test_rotates();
        int e, bc;
        launch(32'h80000001, 32'd4, ROL);
        wait_finish(e, bc);
        tests++; if (result !== 32'h00000018) begin fails++; $display("FAIL rol_result: got %h want 00000018", result); end
        $display("[TB] rol 80000001 by 4 -> %h", result);
        launch(32'h80000001, 32'd4, ROR);
        wait_finish(e, bc);
        tests++; if (result !== 32'h18000000) begin fails++; $display("FAIL ror_result: got %h want 18000000", result); end
        tests++; if (e !== 5) begin fails++; $display("FAIL ror_latency: got %0d want 5", e); end
        $display("[TB] ror 80000001 by 4 -> %h after edge %0d", result, e);
    endtask

    task automatic test_zero_count();
        int e, bc;
        launch(32'h12345678, 32'd0, SHL);
        wait_finish(e, bc);
        tests++; if (e !== 1) begin fails++; $display("FAIL zero_latency: got %0d want 1", e); end
        tests++; if (result !== 32'h12345678) begin fails++; $display("FAIL zero_result: got %h want 12345678", result); end
        $display("[TB] zero count -> %h after edge %0d", result, e);
        launch(32'hA5A5A5A5, 32'd3, 5'b00000);
        wait_finish(e, bc);
        tests++; if (e !== 4) begin fails++; $display("FAIL unknown_op_latency: got %0d want 4", e); end
        tests++; if (result !== 32'hA5A5A5A5) begin fails++; $display("FAIL unknown_op_result: got %h want A5A5A5A5", result); end
        $display("[TB] unknown op by 3 -> %h after edge %0d", result, e);
    endtask

    task automatic test_busy();
        int e, bc;
        launch(32'h000000F0, 32'd4, SHR);
        @(posedge Clock); #1;
        start = 1'b1;
        A = 32'hFFFFFFFF;
        B = 32'd1;
        opSelect = SHL;
        @(posedge Clock); #1;
        start = 1'b0;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL busy_mid_shift: got %b want 1", busy); end
        tests++; if (result !== 32'hA5A5A5A5) begin fails++; $display("FAIL busy_result_hold: got %h want A5A5A5A5", result); end
        wait_finish(e, bc);
        tests++; if (e !== 3) begin fails++; $display("FAIL busy_latency: got %0d want 3", e); end
        tests++; if (result !== 32'h0000000F) begin fails++; $display("FAIL busy_first_operands: got %h want 0000000F", result); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL busy_no_second_op: got %b want 0", busy); end
        $display("[TB] ignored second start, result %h", result);
    endtask

    task automatic test_back_to_back();
        A = 32'h00000003;
        B = 32'd1;
        opSelect = SHL;
        start = 1'b1;
        @(posedge Clock); #1;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_accept: got busy %b want 1", busy); end
        @(posedge Clock); #1;
        @(posedge Clock); #1;
        tests++; if (finished !== 1'b1 || result !== 32'h00000006) begin fails++; $display("FAIL b2b_first_done: got finished %b result %h want 1 00000006", finished, result); end
        A = 32'h00000010;
        @(posedge Clock); #1;
        tests++; if (busy !== 1'b0 || finished !== 1'b0) begin fails++; $display("FAIL b2b_idle_gap: got busy %b finished %b want 0 0", busy, finished); end
        @(posedge Clock); #1;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_reaccept: got busy %b want 1", busy); end
        start = 1'b0;
        A = 32'h0000DEAD;
        @(posedge Clock); #1;
        tests++; if (result !== 32'h00000006 || finished !== 1'b0) begin fails++; $display("FAIL b2b_hold: got result %h finished %b want 00000006 0", result, finished); end
        @(posedge Clock); #1;
        tests++; if (finished !== 1'b1 || result !== 32'h00000020) begin fails++; $display("FAIL b2b_second_done: got finished %b result %h want 1 00000020", finished, result); end
        @(posedge Clock); #1;
        $display("[TB] back-to-back held start -> %h", result);
    endtask

    task automatic test_reset_mid();
        int e, bc;
        int pulses;
        launch(32'hFFFF0000, 32'd10, SHR);
        for (int k = 0; k < 3; k++) begin
            @(posedge Clock); #1;
        end
        #2;
        clear = 1'b0;
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        tests++; if (result !== 32'd0) begin fails++; $display("FAIL rstmid_result: got %h want 00000000", result); end
        @(posedge Clock); #1;
        @(posedge Clock); #1;
        clear = 1'b1;
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge Clock); #1;
            if (finished) pulses++;
        end
        tests++; if (pulses !== 0) begin fails++; $display("FAIL rstmid_no_finish: got %0d pulses want 0", pulses); end
        tests++; if (result !== 32'd0 || busy !== 1'b0) begin fails++; $display("FAIL rstmid_idle: got result %h busy %b want 00000000 0", result, busy); end
        launch(32'h00000005, 32'd0, SHR);
        wait_finish(e, bc);
        tests++; if (e !== 1 || result !== 32'h00000005) begin fails++; $display("FAIL rstmid_restart: got edge %0d result %h want 1 00000005", e, result); end
        $display("[TB] reset mid-shift, restart -> %h", result);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_shra();
        test_shr_shl();
        test_rotates();
        test_zero_count();
        test_busy();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
